// File: rtl/hub75_fb_loader.sv
// hub75_fb_loader: feeds the HUB75 framebuffer write port from an RGB888
// pixel stream. Pixels go through a small FIFO and are written into the bank
// the display is not reading. Banks swap on the display's frame_sync once the
// whole frame has landed in memory. APB writes own the port when ext_wr is set.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a start-of-frame beat; other beats are dropped
// ST_LOAD    | accepting pixels of the current frame into the FIFO
// ST_WAIT    | frame fully accepted; swap banks on a drained frame_sync

module hub75_fb_loader #(
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [9:0]        pixels_per_row,
    input  logic [7:0]        num_rows,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_data,
    input  logic              s_sof,
    input  logic              ext_wr,
    input  logic              frame_sync,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_data,
    output logic              disp_bank,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int ENT_W = ADDR_W + 24;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [17:0] MAX_PIX = 18'(1) << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, push_idx;
    logic [17:0]        frame_pixels;
    logic [17:0]        last_idx;
    logic [17:0]        idx_ext;
    logic               cfg_ok;
    logic               accept;
    logic               push;
    logic               pop;
    logic               swap;
    logic               sof_err_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]   head;

    assign frame_pixels = {8'd0, pixels_per_row} * {10'd0, num_rows};
    assign cfg_ok       = (frame_pixels != 18'd0) && (frame_pixels <= MAX_PIX);
    assign last_idx     = frame_pixels - 18'd1;
    assign idx_ext      = 18'(idx);

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // Reset is folded in so the stream is never acknowledged while it is held.
    assign s_ready = !reset && enable && cfg_ok && !fifo_full && (state != ST_WAIT);
    assign accept  = s_valid && s_ready;
    assign pop     = enable && !ext_wr && !fifo_empty;

    // Next-state, pixel index and push decision.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        push        = 1'b0;
        push_idx    = idx;
        swap        = 1'b0;
        sof_err_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && s_sof) begin
                    push      = 1'b1;
                    push_idx  = '0;
                    idx_nxt   = IDX_W'(1);
                    state_nxt = (frame_pixels == 18'd1) ? ST_WAIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    push = 1'b1;
                    if (s_sof) begin
                        // Restart the frame at pixel 0 and flag the framing error.
                        sof_err_set = 1'b1;
                        push_idx    = '0;
                        idx_nxt     = IDX_W'(1);
                        state_nxt   = (frame_pixels == 18'd1) ? ST_WAIT : ST_LOAD;
                    end else begin
                        push_idx = idx;
                        idx_nxt  = idx + IDX_W'(1);
                        if (idx_ext == last_idx) begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Only swap once every pixel of the frame has reached memory.
                if (frame_sync && fifo_empty && !mem_wr) begin
                    swap      = 1'b1;
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // FIFO storage; entries carry the bank chosen at accept time.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {~disp_bank, push_idx, s_data};
        end
    end

    // State, FIFO bookkeeping, write port and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_wr     <= 1'b0;
            mem_waddr  <= '0;
            mem_data   <= '0;
            disp_bank  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else if (!enable) begin
            state      <= ST_IDLE;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_wr     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            frame_done <= swap;
            disp_bank  <= disp_bank ^ swap;
            sof_err    <= sof_err | sof_err_set;
            mem_wr     <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                mem_waddr <= head[ENT_W-1:24];
                mem_data  <= {8'h00, head[23:0]};
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Directed bench for hub75_fb_loader: framebuffer writes are captured by a
// monitor and compared against hand-built expected address/data sequences.

module tb_hub75_fb_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  pixels_per_row;
    logic [7:0]  num_rows;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;
    logic        ext_wr;
    logic        frame_sync;
    logic        mem_wr;
    logic [14:0] mem_waddr;
    logic [31:0] mem_data;
    logic        disp_bank;
    logic        frame_done;
    logic        sof_err;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int fd_cnt = 0;

    logic [14:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    hub75_fb_loader dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .pixels_per_row (pixels_per_row),
        .num_rows       (num_rows),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_sof          (s_sof),
        .ext_wr         (ext_wr),
        .frame_sync     (frame_sync),
        .mem_wr         (mem_wr),
        .mem_waddr      (mem_waddr),
        .mem_data       (mem_data),
        .disp_bank      (disp_bank),
        .frame_done     (frame_done),
        .sof_err        (sof_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wq_addr.push_back(mem_waddr);
            wq_data.push_back(mem_data);
            wq_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pix(input int k);
        logic [7:0] a, b, c;
        a = 8'(k + 1);
        b = 8'(k + 2);
        c = 8'(k + 3);
        return {a, b, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [23:0] d, input logic sof);
        logic acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        for (int i = 0; i < 64 && !acc; i++) begin
            #1;
            acc = s_ready;
            step();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic chk_wr(input int i, input logic [14:0] addr, input logic [23:0] rgb);
        if (i < wq_addr.size()) begin
            chk($sformatf("waddr[%0d]", i), {17'd0, wq_addr[i]}, {17'd0, addr});
            chk($sformatf("wdata[%0d]", i), wq_data[i], {8'h00, rgb});
        end else begin
            chk($sformatf("wpresent[%0d]", i), 32'(wq_addr.size()), 32'(i + 1));
        end
    endtask

    // Sends a clean 8-pixel frame with data pix(k0..k0+7), drains, checks writes.
    task automatic frame8(input int k0, input logic [14:0] base);
        clear_q();
        for (int i = 0; i < 8; i++) send(pix(k0 + i), (i == 0));
        steps(4);
        chk("nwrites", 32'(wq_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_wr(i, base + 15'(i), pix(k0 + i));
    endtask

    task automatic swap_check(input logic exp_bank);
        int fd0;
        fd0 = fd_cnt;
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("disp_bank", {31'd0, disp_bank}, {31'd0, exp_bank});
        chk("frame_done_hi", {31'd0, frame_done}, 32'd1);
        step();
        chk("frame_done_lo", {31'd0, frame_done}, 32'd0);
        chk("frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        pixels_per_row = 10'd4;
        num_rows       = 8'd2;
        s_valid        = 1'b0;
        s_data         = '0;
        s_sof          = 1'b0;
        ext_wr         = 1'b0;
        frame_sync     = 1'b0;
        @(negedge clk);
        steps(2);

        // Reset values
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_waddr", {17'd0, mem_waddr}, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_disp_bank", {31'd0, disp_bank}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_sof_err", {31'd0, sof_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_s_ready", {31'd0, s_ready}, 32'd1);
        step();

        // Basic frame into bank 1, 8 consecutive write cycles
        frame8(0, 15'h4000);
        for (int i = 1; i < 8; i++)
            chk($sformatf("consec[%0d]", i), 32'(wq_cyc[i] - wq_cyc[0]), 32'(i));
        chk("wait_s_ready", {31'd0, s_ready}, 32'd0);
        chk("pre_swap_bank", {31'd0, disp_bank}, 32'd0);
        swap_check(1'b1);
        frame8(8, 15'h0000);
        swap_check(1'b0);

        // APB writes hold the port; FIFO fills after 4 beats
        clear_q();
        ext_wr = 1'b1;
        for (int i = 0; i < 4; i++) send(pix(16 + i), (i == 0));
        #1;
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        step();
        chk("hold_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("hold_nwrites", 32'(wq_addr.size()), 32'd0);
        ext_wr = 1'b0;
        for (int i = 4; i < 8; i++) send(pix(16 + i), 1'b0);
        steps(5);
        chk("ext_nwrites", 32'(wq_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_wr(i, 15'h4000 + 15'(i), pix(16 + i));
        swap_check(1'b1);

        // Beats without sof in IDLE are dropped; bank 1 displayed -> writes at 0
        clear_q();
        for (int i = 0; i < 3; i++) send(24'hABCDEF, 1'b0);
        steps(3);
        chk("nosof_nwrites", 32'(wq_addr.size()), 32'd0);
        frame8(24, 15'h0000);
        swap_check(1'b0);

        // sof on the 4th beat restarts the frame and sets sof_err
        clear_q();
        for (int i = 0; i < 3; i++) send(pix(40 + i), (i == 0));
        chk("sof_err_pre", {31'd0, sof_err}, 32'd0);
        send(pix(43), 1'b1);
        chk("sof_err_set", {31'd0, sof_err}, 32'd1);
        for (int i = 4; i < 10; i++) send(pix(40 + i), 1'b0);
        #1;
        chk("sof_not_done", {31'd0, s_ready}, 32'd1);
        send(pix(50), 1'b0);
        #1;
        chk("sof_done_s_ready", {31'd0, s_ready}, 32'd0);
        steps(4);
        chk("sof_nwrites", 32'(wq_addr.size()), 32'd11);
        chk_wr(0, 15'h4000, pix(40));
        chk_wr(1, 15'h4001, pix(41));
        chk_wr(2, 15'h4002, pix(42));
        for (int j = 0; j < 8; j++) chk_wr(3 + j, 15'h4000 + 15'(j), pix(43 + j));
        swap_check(1'b1);
        chk("sof_err_sticky", {31'd0, sof_err}, 32'd1);

        // frame_sync ignored while pixels remain queued
        clear_q();
        for (int i = 0; i < 6; i++) send(pix(60 + i), (i == 0));
        step();
        ext_wr = 1'b1;
        send(pix(66), 1'b0);
        send(pix(67), 1'b0);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("noswap_bank", {31'd0, disp_bank}, 32'd1);
        chk("noswap_done", {31'd0, frame_done}, 32'd0);
        chk("noswap_nwrites", 32'(wq_addr.size()), 32'd6);
        ext_wr = 1'b0;
        steps(4);
        chk("drain_nwrites", 32'(wq_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_wr(i, 15'h0000 + 15'(i), pix(60 + i));
        swap_check(1'b0);

        // One-pixel frame goes straight to waiting for the swap
        pixels_per_row = 10'd1;
        num_rows       = 8'd1;
        clear_q();
        send(pix(80), 1'b1);
        #1;
        chk("fp1_s_ready", {31'd0, s_ready}, 32'd0);
        steps(3);
        chk("fp1_nwrites", 32'(wq_addr.size()), 32'd1);
        chk_wr(0, 15'h4000, pix(80));
        swap_check(1'b1);

        // Zero-sized frame is rejected
        num_rows = 8'd0;
        #1;
        chk("cfg_zero_s_ready", {31'd0, s_ready}, 32'd0);
        pixels_per_row = 10'd4;
        num_rows       = 8'd2;
        #1;
        chk("cfg_ok_s_ready", {31'd0, s_ready}, 32'd1);
        step();

        // enable=0 flushes the FIFO and returns to IDLE
        clear_q();
        ext_wr = 1'b1;
        send(pix(90), 1'b1);
        enable = 1'b0;
        #1;
        chk("dis_s_ready", {31'd0, s_ready}, 32'd0);
        step();
        enable = 1'b1;
        ext_wr = 1'b0;
        send(pix(91), 1'b0);
        steps(4);
        chk("dis_nwrites", 32'(wq_addr.size()), 32'd0);
        chk("dis_bank_held", {31'd0, disp_bank}, 32'd1);
        chk("dis_sof_err_held", {31'd0, sof_err}, 32'd1);

        // Reset in the middle of a frame with 3 entries buffered
        clear_q();
        ext_wr = 1'b1;
        for (int i = 0; i < 3; i++) send(pix(100 + i), (i == 0));
        reset = 1'b1;
        step();
        chk("mid_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rst_bank", {31'd0, disp_bank}, 32'd0);
        chk("mid_rst_sof_err", {31'd0, sof_err}, 32'd0);
        reset  = 1'b0;
        ext_wr = 1'b0;
        steps(5);
        chk("mid_rst_nwrites", 32'(wq_addr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
